// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - MIPS multiply/divide unit owning HI/LO
// Results are computed at the accept edge and held in pending until the busy countdown expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_dz_q, pend_dz_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        accept;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [63:0] a_ext, b_ext, prod;

    // Division runs on magnitudes so INT_MIN / -1 and divide-by-zero never hit the native operator.
    always_comb begin
        a_neg    = (op == OP_DIV) && rs_data[31];
        b_neg    = (op == OP_DIV) && rt_data[31];
        a_mag    = a_neg ? (32'd0 - rs_data) : rs_data;
        b_mag    = b_neg ? (32'd0 - rt_data) : rt_data;
        div_zero = (rt_data == 32'd0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
        a_ext    = (op == OP_MULT) ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
        b_ext    = (op == OP_MULT) ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};
        prod     = a_ext * b_ext;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        cnt_d     = cnt_q;
        accept    = start && (cnt_q == 4'd0);

        if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    pend_dz_d = 1'b0;
                    cnt_d     = MULT_N;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    pend_dz_d = div_zero;
                    cnt_d     = DIV_N;
                end
                OP_MTHI: hi_d = rs_data;
                OP_MTLO: lo_d = rs_data;
                default: ;
            endcase
        end

        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && !pend_dz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy   = (cnt_q != 4'd0);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
